scoreboard_mp: RTL and testbench

//  Parametrised multi-port register scoreboard for the compute-unit issue stage; next generation of the 1-bit busy scoreboard.

---
 rtl/scoreboard_mp_pkg.sv | 26 ++
 rtl/scoreboard_mp_ctr.sv | 62 ++++++
 rtl/scoreboard_mp.sv | 191 +++++++++++++++++++
 tb/tb_scoreboard_mp.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scoreboard_mp_pkg.sv
// Shared register-class definitions for the issue-stage scoreboard.
// Contents:
//   reg_class_e - register class encoding (SCALAR, FP, VEC, NONE)
//   CLS_W       - width of a register class field
//   REG_IDX_W   - width of a register index field
//   is_tracked  - true when a (class, register) pair can ever hold a pending write
package scoreboard_mp_pkg;

  typedef enum logic [1:0] {
    SCALAR = 2'd0,
    FP     = 2'd1,
    VEC    = 2'd2,
    NONE   = 2'd3
  } reg_class_e;

  localparam int CLS_W     = 2;
  localparam int REG_IDX_W = 5;

  // x0 is hardwired and class NONE means "no register", so neither is ever counted
  function automatic logic is_tracked(input logic [CLS_W-1:0]     cls,
                                      input logic [REG_IDX_W-1:0] idx);
    return (reg_class_e'(cls) != NONE) &&
           !((reg_class_e'(cls) == SCALAR) && (idx == '0));
  endfunction

endpackage

// File: rtl/scoreboard_mp_ctr.sv
// sb_pend_ctr: one scoreboard entry's pending-write counter.
// The counter adds every issue hit and subtracts every writeback/squash hit in
// one step, clamping at zero (reported on underflow) and at all-ones.
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset
//   inc        - number of accepted issues writing this entry this cycle
//   dec        - number of writeback plus squash hits on this entry this cycle
//   clr        - synchronous clear, overrides inc/dec
//   cnt        - current pending count
//   nz         - count is non-zero
//   sat        - count is at its maximum
//   underflow  - this cycle's update would go below zero
module sb_pend_ctr #(
  parameter int CNT_W = 2,
  parameter int INC_W = 2,
  parameter int DEC_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [INC_W-1:0] inc,
  input  logic [DEC_W-1:0] dec,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             nz,
  output logic             sat,
  output logic             underflow
);

  localparam int SUM_W = CNT_W + INC_W + DEC_W;
  localparam logic [SUM_W-1:0] MAX_V = SUM_W'((1 << CNT_W) - 1);

  logic [SUM_W-1:0] up;
  logic [SUM_W-1:0] diff;
  logic [CNT_W-1:0] nxt;

  // Add first so a same-cycle issue and writeback cancel instead of underflowing
  always_comb begin
    up        = SUM_W'(cnt) + SUM_W'(inc);
    diff      = up - SUM_W'(dec);
    underflow = (up < SUM_W'(dec));
    nxt       = diff[CNT_W-1:0];
    if (underflow) begin
      nxt = '0;
    end else if (diff > MAX_V) begin
      nxt = '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else begin
      cnt <= nxt;
    end
  end

  assign nz  = |cnt;
  assign sat = &cnt;

endmodule

// File: rtl/scoreboard_mp.sv
// scoreboard_mp: multi-port pending-write scoreboard for the issue stage.
// Holds a saturating pending-write counter per (class, register) and flags
// issue slots that must not issue because of RAW, WAW or intra-bundle hazards.
// Ports:
//   clk, rst_n                  - clock and asynchronous active-low reset
//   iss_valid/accept            - slot occupied / slot issued this cycle
//   iss_rs1_*, iss_rs2_*, iss_rd_* - operand use flag, class, index, bypass
//   iss_stall                   - combinational per-slot stall
//   wb_valid/cls/rd             - writeback ports, each retires one pending write
//   fl_valid/rd_v/cls/rd        - squash ports for killed in-flight instructions
//   flush_all                   - clear the whole table next edge
//   idle                        - every counter is zero
//   err_underflow               - sticky: a decrement found nothing pending
module scoreboard_mp
  import scoreboard_mp_pkg::*;
#(
  parameter int N_ISSUE   = 2,
  parameter int N_WB      = 5,
  parameter int N_FLUSH   = 3,
  parameter int N_CLASS   = 3,
  parameter int N_REG     = 32,
  parameter int CNT_W     = 2,
  parameter bit ALLOW_WAW = 1'b1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [N_ISSUE-1:0]                  iss_valid,
  input  logic [N_ISSUE-1:0]                  iss_rs1_v,
  input  logic [N_ISSUE-1:0]                  iss_rs2_v,
  input  logic [N_ISSUE-1:0][CLS_W-1:0]       iss_rs1_cls,
  input  logic [N_ISSUE-1:0][CLS_W-1:0]       iss_rs2_cls,
  input  logic [N_ISSUE-1:0][CLS_W-1:0]       iss_rd_cls,
  input  logic [N_ISSUE-1:0][REG_IDX_W-1:0]   iss_rs1,
  input  logic [N_ISSUE-1:0][REG_IDX_W-1:0]   iss_rs2,
  input  logic [N_ISSUE-1:0][REG_IDX_W-1:0]   iss_rd,
  input  logic [N_ISSUE-1:0]                  iss_rs1_fwd,
  input  logic [N_ISSUE-1:0]                  iss_rs2_fwd,
  input  logic [N_ISSUE-1:0]                  iss_rd_v,
  input  logic [N_ISSUE-1:0]                  iss_accept,
  output logic [N_ISSUE-1:0]                  iss_stall,
  input  logic [N_WB-1:0]                     wb_valid,
  input  logic [N_WB-1:0][CLS_W-1:0]          wb_cls,
  input  logic [N_WB-1:0][REG_IDX_W-1:0]      wb_rd,
  input  logic [N_FLUSH-1:0]                  fl_valid,
  input  logic [N_FLUSH-1:0]                  fl_rd_v,
  input  logic [N_FLUSH-1:0][CLS_W-1:0]       fl_cls,
  input  logic [N_FLUSH-1:0][REG_IDX_W-1:0]   fl_rd,
  input  logic                                flush_all,
  output logic                                idle,
  output logic                                err_underflow
);

  // Lookup tables span every encodable class; classes without counters read as zero
  localparam int N_TAB = 1 << CLS_W;
  localparam int INC_W = $clog2(N_ISSUE + 1);
  localparam int DEC_W = $clog2(N_WB + N_FLUSH + 1);

  logic [N_TAB-1:0][N_REG-1:0][CNT_W-1:0]   cnt_tab;
  logic [N_TAB-1:0][N_REG-1:0]              nz_tab;
  logic [N_TAB-1:0][N_REG-1:0]              sat_tab;
  logic [N_TAB-1:0][N_REG-1:0]              uf_tab;
  logic [N_CLASS-1:0][N_REG-1:0][INC_W-1:0] inc_tab;
  logic [N_CLASS-1:0][N_REG-1:0][DEC_W-1:0] dec_tab;
  logic [N_ISSUE-1:0]                       iss_hit;
  logic [N_WB-1:0]                          wb_hit;
  logic [N_FLUSH-1:0]                       fl_hit;
  logic                                     raw;
  logic                                     waw;
  logic                                     intra;
  logic                                     chain;
  logic                                     err_q;

  function automatic logic tracked(input logic [CLS_W-1:0]     cls,
                                   input logic [REG_IDX_W-1:0] idx);
    return (int'(cls) < N_CLASS) && is_tracked(cls, idx);
  endfunction

  // Hazard evaluation walks the slots oldest first so a stall ripples to younger slots
  always_comb begin
    iss_stall = '0;
    raw       = 1'b0;
    waw       = 1'b0;
    intra     = 1'b0;
    chain     = 1'b0;
    for (int i = 0; i < N_ISSUE; i++) begin
      raw = (iss_rs1_v[i] && !iss_rs1_fwd[i] && tracked(iss_rs1_cls[i], iss_rs1[i]) &&
             nz_tab[iss_rs1_cls[i]][iss_rs1[i]]) ||
            (iss_rs2_v[i] && !iss_rs2_fwd[i] && tracked(iss_rs2_cls[i], iss_rs2[i]) &&
             nz_tab[iss_rs2_cls[i]][iss_rs2[i]]);
      waw = iss_rd_v[i] && tracked(iss_rd_cls[i], iss_rd[i]) &&
            (ALLOW_WAW ? sat_tab[iss_rd_cls[i]][iss_rd[i]] : nz_tab[iss_rd_cls[i]][iss_rd[i]]);
      intra = 1'b0;
      for (int k = 0; k < i; k++) begin
        if (iss_valid[k] && iss_rd_v[k] && tracked(iss_rd_cls[k], iss_rd[k])) begin
          if (iss_rs1_v[i] && iss_rs1_cls[i] == iss_rd_cls[k] && iss_rs1[i] == iss_rd[k]) intra = 1'b1;
          if (iss_rs2_v[i] && iss_rs2_cls[i] == iss_rd_cls[k] && iss_rs2[i] == iss_rd[k]) intra = 1'b1;
          if (iss_rd_v[i]  && iss_rd_cls[i]  == iss_rd_cls[k] && iss_rd[i]  == iss_rd[k]) intra = 1'b1;
        end
      end
      iss_stall[i] = iss_valid[i] && (raw || waw || intra || chain);
      chain        = iss_stall[i];
    end
  end

  // A stalled slot never counts even if the issue logic accepts it anyway
  always_comb begin
    iss_hit = '0;
    wb_hit  = '0;
    fl_hit  = '0;
    for (int i = 0; i < N_ISSUE; i++) begin
      iss_hit[i] = iss_valid[i] && iss_accept[i] && !iss_stall[i] && iss_rd_v[i] &&
                   tracked(iss_rd_cls[i], iss_rd[i]);
    end
    for (int w = 0; w < N_WB; w++) begin
      wb_hit[w] = wb_valid[w] && tracked(wb_cls[w], wb_rd[w]);
    end
    for (int f = 0; f < N_FLUSH; f++) begin
      fl_hit[f] = fl_valid[f] && fl_rd_v[f] && tracked(fl_cls[f], fl_rd[f]);
    end
  end

  // Every port is summed per entry so coincident hits on one register all count
  always_comb begin
    inc_tab = '0;
    dec_tab = '0;
    for (int c = 0; c < N_CLASS; c++) begin
      for (int r = 0; r < N_REG; r++) begin
        for (int i = 0; i < N_ISSUE; i++) begin
          if (iss_hit[i] && iss_rd_cls[i] == CLS_W'(c) && iss_rd[i] == REG_IDX_W'(r))
            inc_tab[c][r] = inc_tab[c][r] + INC_W'(1);
        end
        for (int w = 0; w < N_WB; w++) begin
          if (wb_hit[w] && wb_cls[w] == CLS_W'(c) && wb_rd[w] == REG_IDX_W'(r))
            dec_tab[c][r] = dec_tab[c][r] + DEC_W'(1);
        end
        for (int f = 0; f < N_FLUSH; f++) begin
          if (fl_hit[f] && fl_cls[f] == CLS_W'(c) && fl_rd[f] == REG_IDX_W'(r))
            dec_tab[c][r] = dec_tab[c][r] + DEC_W'(1);
        end
      end
    end
  end

  for (genvar c = 0; c < N_TAB; c++) begin : g_cls
    for (genvar r = 0; r < N_REG; r++) begin : g_reg
      if (c < N_CLASS) begin : g_ctr
        sb_pend_ctr #(
          .CNT_W (CNT_W),
          .INC_W (INC_W),
          .DEC_W (DEC_W)
        ) u_ctr (
          .clk       (clk),
          .rst_n     (rst_n),
          .inc       (inc_tab[c][r]),
          .dec       (dec_tab[c][r]),
          .clr       (flush_all),
          .cnt       (cnt_tab[c][r]),
          .nz        (nz_tab[c][r]),
          .sat       (sat_tab[c][r]),
          .underflow (uf_tab[c][r])
        );
      end else begin : g_none
        assign cnt_tab[c][r] = '0;
        assign nz_tab[c][r]  = 1'b0;
        assign sat_tab[c][r] = 1'b0;
        assign uf_tab[c][r]  = 1'b0;
      end
    end
  end

  // flush_all wins over an underflow in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (flush_all) begin
      err_q <= 1'b0;
    end else if (|uf_tab) begin
      err_q <= 1'b1;
    end
  end

  assign err_underflow = err_q;

  // Derived only from counter flops, so it moves at clock edges or on reset
  assign idle = (cnt_tab == '0);

  a_no_accept_when_stalled : assert property (
    @(posedge clk) disable iff (!rst_n) ((iss_valid & iss_accept & iss_stall) == '0)
  );

endmodule

// File: tb/tb_scoreboard_mp.sv
// Testbench for scoreboard_mp: table-driven directed rows, hand-written
// multi-cycle sequences and randomized traffic against a counting model.
module tb_scoreboard_mp;

  localparam int NI   = 2;
  localparam int NW   = 5;
  localparam int NF   = 3;
  localparam int MAXC = 3;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NI-1:0]       iss_valid, iss_rs1_v, iss_rs2_v, iss_rs1_fwd, iss_rs2_fwd;
  logic [NI-1:0]       iss_rd_v, iss_accept, iss_stall;
  logic [NI-1:0][1:0]  iss_rs1_cls, iss_rs2_cls, iss_rd_cls;
  logic [NI-1:0][4:0]  iss_rs1, iss_rs2, iss_rd;
  logic [NW-1:0]       wb_valid;
  logic [NW-1:0][1:0]  wb_cls;
  logic [NW-1:0][4:0]  wb_rd;
  logic [NF-1:0]       fl_valid, fl_rd_v;
  logic [NF-1:0][1:0]  fl_cls;
  logic [NF-1:0][4:0]  fl_rd;
  logic                flush_all, idle, err_underflow;

  always #5 clk = ~clk;

  scoreboard_mp #(
    .N_ISSUE(NI), .N_WB(NW), .N_FLUSH(NF), .N_CLASS(3), .N_REG(32), .CNT_W(2), .ALLOW_WAW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_rs1_v(iss_rs1_v), .iss_rs2_v(iss_rs2_v),
    .iss_rs1_cls(iss_rs1_cls), .iss_rs2_cls(iss_rs2_cls), .iss_rd_cls(iss_rd_cls),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
    .iss_rs1_fwd(iss_rs1_fwd), .iss_rs2_fwd(iss_rs2_fwd),
    .iss_rd_v(iss_rd_v), .iss_accept(iss_accept), .iss_stall(iss_stall),
    .wb_valid(wb_valid), .wb_cls(wb_cls), .wb_rd(wb_rd),
    .fl_valid(fl_valid), .fl_rd_v(fl_rd_v), .fl_cls(fl_cls), .fl_rd(fl_rd),
    .flush_all(flush_all), .idle(idle), .err_underflow(err_underflow)
  );

  typedef struct {
    bit v; bit r1v; int r1c; int r1; bit r1f; bit r2v; int r2c; int r2;
    bit rdv; int rdc; int rd; bit acc;
  } slot_t;

  typedef struct {
    slot_t s0; slot_t s1; bit wbv; int wbc; int wbr;
    bit [1:0] exp_stall; bit exp_idle; bit exp_err;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int mcnt[4][32];
  bit merr;
  vec_t tbl[$];

  // Reference model: plain pending-write counts per register
  function automatic bit trk(int c, int r);
    return (c != 3) && !(c == 0 && r == 0);
  endfunction

  task automatic modelClear();
    foreach (mcnt[c, r]) mcnt[c][r] = 0;
    merr = 1'b0;
  endtask

  function automatic bit modelIdle();
    foreach (mcnt[c, r]) if (mcnt[c][r] != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit [1:0] modelStall();
    bit [1:0] s;
    bit prev;
    bit h;
    int c1, r1, c2, r2, cd, rd, ck, rk;
    s = '0;
    prev = 1'b0;
    for (int i = 0; i < NI; i++) begin
      h  = 1'b0;
      c1 = int'(iss_rs1_cls[i]); r1 = int'(iss_rs1[i]);
      c2 = int'(iss_rs2_cls[i]); r2 = int'(iss_rs2[i]);
      cd = int'(iss_rd_cls[i]);  rd = int'(iss_rd[i]);
      if (iss_rs1_v[i] && !iss_rs1_fwd[i] && trk(c1, r1) && mcnt[c1][r1] > 0) h = 1'b1;
      if (iss_rs2_v[i] && !iss_rs2_fwd[i] && trk(c2, r2) && mcnt[c2][r2] > 0) h = 1'b1;
      if (iss_rd_v[i] && trk(cd, rd) && mcnt[cd][rd] >= MAXC) h = 1'b1;
      for (int k = 0; k < i; k++) begin
        ck = int'(iss_rd_cls[k]); rk = int'(iss_rd[k]);
        if (iss_valid[k] && iss_rd_v[k] && trk(ck, rk)) begin
          if (iss_rs1_v[i] && c1 == ck && r1 == rk) h = 1'b1;
          if (iss_rs2_v[i] && c2 == ck && r2 == rk) h = 1'b1;
          if (iss_rd_v[i]  && cd == ck && rd == rk) h = 1'b1;
        end
      end
      s[i] = iss_valid[i] && (h || prev);
      prev = s[i];
    end
    return s;
  endfunction

  task automatic modelUpdate(input bit [1:0] st);
    int delta[4][32];
    int n;
    if (flush_all) begin
      modelClear();
      return;
    end
    foreach (delta[c, r]) delta[c][r] = 0;
    for (int i = 0; i < NI; i++)
      if (iss_valid[i] && iss_accept[i] && !st[i] && iss_rd_v[i] && trk(int'(iss_rd_cls[i]), int'(iss_rd[i])))
        delta[iss_rd_cls[i]][iss_rd[i]]++;
    for (int w = 0; w < NW; w++)
      if (wb_valid[w] && trk(int'(wb_cls[w]), int'(wb_rd[w])))
        delta[wb_cls[w]][wb_rd[w]]--;
    for (int f = 0; f < NF; f++)
      if (fl_valid[f] && fl_rd_v[f] && trk(int'(fl_cls[f]), int'(fl_rd[f])))
        delta[fl_cls[f]][fl_rd[f]]--;
    foreach (mcnt[c, r]) begin
      n = mcnt[c][r] + delta[c][r];
      if (n < 0) begin
        merr = 1'b1;
        n = 0;
      end
      if (n > MAXC) n = MAXC;
      mcnt[c][r] = n;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clearInputs();
    iss_valid = '0; iss_rs1_v = '0; iss_rs2_v = '0; iss_rs1_fwd = '0; iss_rs2_fwd = '0;
    iss_rd_v = '0; iss_accept = '0;
    iss_rs1_cls = '0; iss_rs2_cls = '0; iss_rd_cls = '0; iss_rs1 = '0; iss_rs2 = '0; iss_rd = '0;
    wb_valid = '0; wb_cls = '0; wb_rd = '0;
    fl_valid = '0; fl_rd_v = '0; fl_cls = '0; fl_rd = '0;
    flush_all = 1'b0;
  endtask

  task automatic driveSlot(input int i, input slot_t s);
    iss_valid[i] = s.v; iss_rs1_v[i] = s.r1v; iss_rs1_cls[i] = 2'(s.r1c); iss_rs1[i] = 5'(s.r1);
    iss_rs1_fwd[i] = s.r1f; iss_rs2_v[i] = s.r2v; iss_rs2_cls[i] = 2'(s.r2c); iss_rs2[i] = 5'(s.r2);
    iss_rd_v[i] = s.rdv; iss_rd_cls[i] = 2'(s.rdc); iss_rd[i] = 5'(s.rd); iss_accept[i] = s.acc;
  endtask

  task automatic applyStimulus(input vec_t v);
    clearInputs();
    driveSlot(0, v.s0);
    driveSlot(1, v.s1);
    wb_valid[0] = v.wbv; wb_cls[0] = 2'(v.wbc); wb_rd[0] = 5'(v.wbr);
  endtask

  task automatic tick();
    bit [1:0] st;
    st = modelStall();
    @(posedge clk);
    if (rst_n) modelUpdate(st);
    else modelClear();
    @(negedge clk);
  endtask

  // Inputs are already driven; compare stall, clock once, compare registered state
  task automatic finishRow(input vec_t v, input string name);
    #1;
    checkOutput({name, "_stall"}, 32'(iss_stall), 32'(v.exp_stall));
    tick();
    checkOutput({name, "_idle"}, 32'(idle), 32'(v.exp_idle));
    checkOutput({name, "_err"}, 32'(err_underflow), 32'(v.exp_err));
  endtask

  function automatic slot_t sl(bit v, bit r1v, int r1c, int r1, bit r1f, bit r2v, int r2c, int r2,
                               bit rdv, int rdc, int rd, bit acc);
    slot_t s;
    s.v = v; s.r1v = r1v; s.r1c = r1c; s.r1 = r1; s.r1f = r1f; s.r2v = r2v; s.r2c = r2c; s.r2 = r2;
    s.rdv = rdv; s.rdc = rdc; s.rd = rd; s.acc = acc;
    return s;
  endfunction

  function automatic slot_t nos();                         return sl(0,0,0,0,0,0,0,0,0,0,0,0); endfunction
  function automatic slot_t wr(int c, int r, bit a);       return sl(1,0,0,0,0,0,0,0,1,c,r,a); endfunction
  function automatic slot_t rd1(int c, int r, bit f);      return sl(1,1,c,r,f,0,0,0,0,0,0,0); endfunction
  function automatic slot_t rd2(int c, int r);             return sl(1,0,0,0,0,1,c,r,0,0,0,0); endfunction

  function automatic vec_t mkv(slot_t s0, slot_t s1, bit wbv, int wbc, int wbr,
                               bit [1:0] es, bit ei, bit ee);
    vec_t v;
    v.s0 = s0; v.s1 = s1; v.wbv = wbv; v.wbc = wbc; v.wbr = wbr;
    v.exp_stall = es; v.exp_idle = ei; v.exp_err = ee;
    return v;
  endfunction

  task automatic runVec(input vec_t v, input string name);
    applyStimulus(v);
    finishRow(v, name);
  endtask

  initial begin
    vec_t v;
    bit [1:0] st;

    // Directed rows: RAW on x5, saturation on f3, intra-bundle, x0 and class NONE
    tbl.push_back(mkv(wr(0,5,1),  nos(),          0,0,0, 2'b00, 0, 0));
    tbl.push_back(mkv(rd1(0,5,0), nos(),          0,0,0, 2'b01, 0, 0));
    tbl.push_back(mkv(rd1(0,5,1), nos(),          0,0,0, 2'b00, 0, 0));
    tbl.push_back(mkv(rd1(0,5,0), nos(),          1,0,5, 2'b01, 1, 0));
    tbl.push_back(mkv(rd1(0,5,0), nos(),          0,0,0, 2'b00, 1, 0));
    tbl.push_back(mkv(wr(1,3,1),  nos(),          0,0,0, 2'b00, 0, 0));
    tbl.push_back(mkv(wr(1,3,1),  nos(),          0,0,0, 2'b00, 0, 0));
    tbl.push_back(mkv(wr(1,3,1),  nos(),          0,0,0, 2'b00, 0, 0));
    tbl.push_back(mkv(wr(1,3,0),  rd1(0,1,0),     0,0,0, 2'b11, 0, 0));
    tbl.push_back(mkv(nos(),      nos(),          1,1,3, 2'b00, 0, 0));
    tbl.push_back(mkv(wr(1,3,0),  nos(),          1,1,3, 2'b00, 0, 0));
    tbl.push_back(mkv(nos(),      nos(),          1,1,3, 2'b00, 1, 0));
    tbl.push_back(mkv(wr(0,7,0),  rd2(0,7),       0,0,0, 2'b10, 1, 0));
    tbl.push_back(mkv(wr(0,7,0),  wr(0,7,0),      0,0,0, 2'b10, 1, 0));
    tbl.push_back(mkv(sl(1,1,0,0,0,0,0,0,1,0,0,1), sl(1,1,0,0,0,1,0,0,1,0,0,1), 0,0,0, 2'b00, 1, 0));
    tbl.push_back(mkv(wr(3,7,1),  sl(1,1,3,7,0,0,0,0,1,3,7,1), 0,0,0, 2'b00, 1, 0));
    tbl.push_back(mkv(sl(0,0,0,0,0,0,0,0,1,0,7,0), rd1(0,7,0), 0,0,0, 2'b00, 1, 0));
    tbl.push_back(mkv(sl(1,1,1,9,0,0,0,0,0,0,0,1), wr(0,9,1),  0,0,0, 2'b00, 0, 0));
    tbl.push_back(mkv(rd2(0,9),   nos(),          0,0,0, 2'b01, 0, 0));
    tbl.push_back(mkv(nos(),      nos(),          1,0,9, 2'b00, 1, 0));
    tbl.push_back(mkv(wr(1,8,0),  rd1(0,8,0),     0,0,0, 2'b00, 1, 0));

    // Reset state: table empty, stall still reacts to the bundle
    rst_n = 1'b0;
    modelClear();
    applyStimulus(mkv(wr(0,5,0), rd1(0,5,0), 0,0,0, 2'b10, 1, 0));
    #2;
    checkOutput("rst_stall", 32'(iss_stall), 32'(2'b10));
    checkOutput("rst_idle", 32'(idle), 32'd1);
    checkOutput("rst_err", 32'(err_underflow), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) runVec(tbl[i], $sformatf("row%0d", i));

    // Issue and writeback on v2 in one cycle cancel; two squashes retire two writes
    runVec(mkv(wr(2,2,1), nos(), 0,0,0, 2'b00, 0, 0), "v2_issue");
    runVec(mkv(wr(2,2,1), nos(), 1,2,2, 2'b00, 0, 0), "v2_net");
    runVec(mkv(rd1(2,2,0), nos(), 0,0,0, 2'b01, 0, 0), "v2_still1");
    runVec(mkv(wr(2,2,1), nos(), 0,0,0, 2'b00, 0, 0), "v2_two");
    v = mkv(nos(), nos(), 0,0,0, 2'b00, 1, 0);
    applyStimulus(v);
    fl_valid = 3'b111; fl_rd_v = 3'b011;
    for (int f = 0; f < NF; f++) begin fl_cls[f] = 2'd2; fl_rd[f] = 5'd2; end
    finishRow(v, "v2_squash");

    // Underflow is sticky until flush_all, which also beats a concurrent issue
    runVec(mkv(nos(), nos(), 1,0,9, 2'b00, 1, 1), "uf_x9");
    runVec(mkv(wr(0,10,1), nos(), 0,0,0, 2'b00, 0, 1), "uf_hold");
    v = mkv(wr(0,4,1), nos(), 0,0,0, 2'b00, 1, 0);
    applyStimulus(v);
    flush_all = 1'b1;
    finishRow(v, "flush_all");
    runVec(mkv(rd1(0,4,0), nos(), 0,0,0, 2'b00, 1, 0), "after_flush");

    // Asynchronous reset in the middle of traffic
    runVec(mkv(wr(0,11,1), wr(1,12,1), 1,0,9, 2'b00, 0, 1), "pre_rst");
    applyStimulus(mkv(rd1(0,11,0), nos(), 0,0,0, 2'b01, 0, 1));
    #1;
    checkOutput("pre_rst_stall", 32'(iss_stall), 32'(2'b01));
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_idle", 32'(idle), 32'd1);
    checkOutput("async_rst_err", 32'(err_underflow), 32'd0);
    checkOutput("async_rst_stall", 32'(iss_stall), 32'(2'b00));
    modelClear();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic on a few registers per class so hazards are frequent
    for (int n = 0; n < 1500; n++) begin
      clearInputs();
      for (int i = 0; i < NI; i++) begin
        iss_valid[i]   = ($urandom_range(0, 3) != 0);
        iss_rs1_v[i]   = $urandom_range(0, 1);
        iss_rs2_v[i]   = $urandom_range(0, 1);
        iss_rs1_fwd[i] = ($urandom_range(0, 4) == 0);
        iss_rs2_fwd[i] = ($urandom_range(0, 4) == 0);
        iss_rd_v[i]    = ($urandom_range(0, 4) < 3);
        iss_rs1_cls[i] = 2'($urandom_range(0, 3)); iss_rs1[i] = 5'($urandom_range(0, 3));
        iss_rs2_cls[i] = 2'($urandom_range(0, 3)); iss_rs2[i] = 5'($urandom_range(0, 3));
        iss_rd_cls[i]  = 2'($urandom_range(0, 3)); iss_rd[i]  = 5'($urandom_range(0, 3));
      end
      for (int w = 0; w < NW; w++) begin
        wb_valid[w] = ($urandom_range(0, 11) == 0);
        wb_cls[w] = 2'($urandom_range(0, 3)); wb_rd[w] = 5'($urandom_range(0, 3));
      end
      for (int f = 0; f < NF; f++) begin
        fl_valid[f] = ($urandom_range(0, 19) == 0);
        fl_rd_v[f]  = ($urandom_range(0, 3) != 0);
        fl_cls[f] = 2'($urandom_range(0, 3)); fl_rd[f] = 5'($urandom_range(0, 3));
      end
      flush_all = ($urandom_range(0, 63) == 0);
      st = modelStall();
      for (int i = 0; i < NI; i++)
        iss_accept[i] = iss_valid[i] && !st[i] && ($urandom_range(0, 3) != 0);
      #1;
      checkOutput($sformatf("rand_stall_%0d", n), 32'(iss_stall), 32'(st));
      tick();
      checkOutput($sformatf("rand_idle_%0d", n), 32'(idle), 32'(modelIdle()));
      checkOutput($sformatf("rand_err_%0d", n), 32'(err_underflow), 32'(merr));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
